led_pwm_ctrl: RTL
=================

Name: led_pwm_ctrl

Overview:
- Parametrised multi-channel LED PWM/pattern generator.
- Drives the PWM inputs of the iCE40 hard RGB LED driver, one output per LED colour.
- Each channel has its own mode (off, static, blink, breathe) and 8-bit-class duty.
- Configuration arrives over a valid/ready write port and is applied glitch-free, only at PWM period boundaries.

Parameters:
- NCH, 3: number of LED channels.
- PWM_BITS, 8: width of the PWM counter and duty; PWM period is 2**PWM_BITS clocks.
- STEP_LOG2, 16: a step strobe fires every 2**STEP_LOG2 clocks. Must be >= PWM_BITS.
- BLINK_LOG2, 7: blink phase toggles every 2**BLINK_LOG2 step strobes.

Ports:
- clk  in  1  system clock (48 MHz)
- rst_n  in  1  asynchronous active-low reset
- cfg_valid  in  1  configuration write request
- cfg_ready  out  1  block can accept a write
- cfg_ch  in  $clog2(NCH) (min 1)  target channel
- cfg_mode  in  2  0=OFF, 1=ON, 2=BLINK, 3=BREATHE
- cfg_duty  in  PWM_BITS  peak duty
- apply_pulse  out  1  one-cycle pulse when the pending write takes effect
- pwm  out  NCH  per-channel PWM output, to the LED driver PWM pins

Behaviour:
- Reset (async assert, sync release):
  - all channels mode OFF, duty 0, level 0, blink phase on, breathe direction up.
  - pwm_cnt=0, step counter=0, pending empty.
  - outputs: pwm=0, cfg_ready=1, apply_pulse=0.
- pwm_cnt free-runs, +1 per clock, wraps at 2**PWM_BITS-1 -> 0. The wrap cycle is the cycle where pwm_cnt == all-ones.
- step_strobe asserts for one clock when the STEP_LOG2-bit step counter is all-ones.
- Handshake:
  - A write transfers on cfg_valid & cfg_ready, into a single pending register.
  - cfg_ready = !pending. It is low from the cycle after acceptance until the cycle after apply.
  - cfg_ch >= NCH is accepted and discarded at apply; apply_pulse still fires.
- Apply, on the wrap cycle with pending set:
  - The channel's mode and duty are updated.
  - level=0, blink phase=on, direction=up, blink counter=0.
  - pending is cleared and apply_pulse=1 on the following cycle.
  - A write accepted in the wrap cycle itself applies at the next wrap, never the same one.
- Effective level per channel:
  - OFF: 0.
  - ON: duty.
  - BLINK: duty when phase on, else 0. The per-channel blink counter increments on step_strobe; the phase toggles when it wraps.
  - BREATHE: on each step_strobe, level +1 while up, -1 while down.
    - Reaching duty flips direction to down; reaching 0 flips to up.
    - duty=0 keeps level at 0.
    - Level changes made mid-period are latched for compare only at the wrap (compare level is double-buffered).
- Output:
  - pwm[c] is registered: (cmp_level[c] > pwm_cnt) | (cmp_level[c] == all-ones). Latency 1 clock.
  - Duty all-ones gives constant high. Duty 0 gives constant low.
- step_strobe coinciding with apply on the same channel: the apply wins and level is reset to 0.
- Reset asserted mid-period forces pwm=0 immediately. Any pending write is lost.

Decomposition:
- Shared package led_pkg holds:
  - mode enum: LED_OFF, LED_ON, LED_BLINK, LED_BREATHE.
  - RGBA current-mode/current-level string constants used alongside the hard driver.
- One sub-module led_pwm_chan (per-channel mode/level/blink/breathe state and comparator), generated NCH times.
- The top level holds the shared pwm_cnt, step counter and config handshake.

Test Plan:
All scenarios use PWM_BITS=4, STEP_LOG2=5, BLINK_LOG2=2, NCH=3.
1. Reset: hold rst_n=0 for 3 clocks, release -> pwm=000, cfg_ready=1, apply_pulse never asserts; pwm stays 000 for 64 clocks.
2. Static duty: write ch0 ON duty=4 -> apply_pulse exactly one cycle after the next wrap; thereafter pwm[0] high 4 of every 16 clocks. Duty=15 -> pwm[0] constantly 1.
3. Handshake: after one accepted write, hold cfg_valid=1 -> cfg_ready=0 until the cycle after apply; second write accepted then and applied one full period (16 clocks) later. Write to cfg_ch=3 -> apply_pulse fires, pwm unchanged.
4. Blink: ch1 BLINK duty=8 -> pwm[1] shows 8/16 duty for 4 strobes (128 clocks), then low for 128 clocks, repeating.
5. Breathe: ch2 BREATHE duty=3 -> per-period high count follows 0,1,2,3,2,1,0,1..., changing once per step strobe (32 clocks). Duty=0 -> pwm[2] always 0.
6. Reset mid-operation: assert rst_n=0 while pwm=111 -> pwm=000 asynchronously, before the next clk edge; after release all channels OFF.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and constants for the LED PWM/pattern generator.
// The RGBA strings are the attribute values used on the iCE40 hard LED driver.
package led_pkg;

  typedef enum logic [1:0] {
    LED_OFF     = 2'd0,
    LED_ON      = 2'd1,
    LED_BLINK   = 2'd2,
    LED_BREATHE = 2'd3
  } led_mode_e;

  // Half-current mode, lowest current step on each colour of SB_RGBA_DRV.
  localparam RGBA_CURRENT_MODE = "0b1";
  localparam RGBA_CURRENT_R    = "0b000001";
  localparam RGBA_CURRENT_G    = "0b000001";
  localparam RGBA_CURRENT_B    = "0b000001";

endpackage

// File: rtl/led_pwm_chan.sv
// One LED channel: mode/duty state, blink and breathe sequencing, and the
// double-buffered compare level feeding a registered PWM comparator.
module led_pwm_chan
  import led_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter int BLINK_LOG2 = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  input  logic                wrap_i,
  input  logic                step_i,
  input  logic                apply_i,
  input  led_mode_e           mode_i,
  input  logic [PWM_BITS-1:0] duty_i,
  output logic                pwm_o
);

  localparam logic [PWM_BITS-1:0] LVL_ONE = PWM_BITS'(1);

  led_mode_e             mode_q, mode_d;
  logic [PWM_BITS-1:0]   duty_q, duty_d;
  logic [PWM_BITS-1:0]   level_q, level_d;
  logic                  phase_q, phase_d;
  logic                  up_q, up_d;
  logic [BLINK_LOG2-1:0] blink_q, blink_d;
  logic [PWM_BITS-1:0]   cmp_q, cmp_d;
  logic                  pwm_q, pwm_d;

  function automatic logic [PWM_BITS-1:0] eff_level(led_mode_e m, logic [PWM_BITS-1:0] d,
                                                    logic ph, logic [PWM_BITS-1:0] lv);
    case (m)
      LED_ON:      return d;
      LED_BLINK:   return ph ? d : '0;
      LED_BREATHE: return lv;
      default:     return '0;
    endcase
  endfunction

  always_comb begin
    mode_d  = mode_q;
    duty_d  = duty_q;
    level_d = level_q;
    phase_d = phase_q;
    up_d    = up_q;
    blink_d = blink_q;
    // A new configuration overrides any step landing on the same edge.
    if (apply_i) begin
      mode_d  = mode_i;
      duty_d  = duty_i;
      level_d = '0;
      phase_d = 1'b1;
      up_d    = 1'b1;
      blink_d = '0;
    end else if (step_i) begin
      blink_d = blink_q + 1'b1;
      if (blink_q == '1) phase_d = ~phase_q;
      if (mode_q == LED_BREATHE) begin
        if (duty_q == '0) begin
          level_d = '0;
          up_d    = 1'b1;
        end else if (up_q) begin
          if (level_q >= duty_q - LVL_ONE) begin
            level_d = duty_q;
            up_d    = 1'b0;
          end else begin
            level_d = level_q + LVL_ONE;
          end
        end else begin
          if (level_q <= LVL_ONE) begin
            level_d = '0;
            up_d    = 1'b1;
          end else begin
            level_d = level_q - LVL_ONE;
          end
        end
      end
    end
    // Compare level only moves at the period boundary so a period is never torn.
    cmp_d = wrap_i ? eff_level(mode_d, duty_d, phase_d, level_d) : cmp_q;
    pwm_d = (cmp_q > pwm_cnt_i) || (&cmp_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= LED_OFF;
      duty_q  <= '0;
      level_q <= '0;
      phase_q <= 1'b1;
      up_q    <= 1'b1;
      blink_q <= '0;
      cmp_q   <= '0;
      pwm_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      duty_q  <= duty_d;
      level_q <= level_d;
      phase_q <= phase_d;
      up_q    <= up_d;
      blink_q <= blink_d;
      cmp_q   <= cmp_d;
      pwm_q   <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/led_pwm_ctrl.sv
// Multi-channel LED PWM/pattern generator: shared PWM and step counters, a
// single-entry configuration holding register, and NCH channel instances.
module led_pwm_ctrl
  import led_pkg::*;
#(
  parameter  int NCH        = 3,
  parameter  int PWM_BITS   = 8,
  parameter  int STEP_LOG2  = 16,
  parameter  int BLINK_LOG2 = 7,
  localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [PWM_BITS-1:0] cfg_duty,
  output logic                apply_pulse,
  output logic [NCH-1:0]      pwm
);

  logic [PWM_BITS-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic [STEP_LOG2-1:0] step_cnt_q, step_cnt_d;
  logic                 pend_q, pend_d;
  logic                 apply_q, apply_d;
  logic [CH_W-1:0]      pend_ch_q;
  logic [1:0]           pend_mode_q;
  logic [PWM_BITS-1:0]  pend_duty_q;
  logic                 wrap, step, accept, do_apply;

  always_comb begin
    wrap       = &pwm_cnt_q;
    step       = &step_cnt_q;
    accept     = cfg_valid && !pend_q;
    do_apply   = wrap && pend_q;
    pwm_cnt_d  = pwm_cnt_q + 1'b1;
    step_cnt_d = step_cnt_q + 1'b1;
    pend_d     = pend_q;
    if (do_apply)    pend_d = 1'b0;
    else if (accept) pend_d = 1'b1;
    apply_d    = do_apply;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q  <= '0;
      step_cnt_q <= '0;
      pend_q     <= 1'b0;
      apply_q    <= 1'b0;
    end else begin
      pwm_cnt_q  <= pwm_cnt_d;
      step_cnt_q <= step_cnt_d;
      pend_q     <= pend_d;
      apply_q    <= apply_d;
    end
  end

  // Payload is qualified by pend_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      pend_ch_q   <= cfg_ch;
      pend_mode_q <= cfg_mode;
      pend_duty_q <= cfg_duty;
    end
  end

  assign cfg_ready   = !pend_q;
  assign apply_pulse = apply_q;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    led_pwm_chan #(
      .PWM_BITS   (PWM_BITS),
      .BLINK_LOG2 (BLINK_LOG2)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .pwm_cnt_i (pwm_cnt_q),
      .wrap_i    (wrap),
      .step_i    (step),
      .apply_i   (do_apply && (pend_ch_q == CH_W'(g))),
      .mode_i    (led_mode_e'(pend_mode_q)),
      .duty_i    (pend_duty_q),
      .pwm_o     (pwm[g])
    );
  end

endmodule
